// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 active-low keypad, debounces one key at a time and buffers its code
module keypad_encoder #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [4:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_held,
  output logic       overflow
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [1:0] IDLE = 2'd0, DEBOUNCE = 2'd1, HELD = 2'd2, RELEASE = 2'd3;
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  logic [DW-1:0] div_cnt;
  logic [1:0] col, state, state_n, row_idx;
  logic [1:0] acc_n, col_n, tot_n;
  logic [3:0] closed, acc_code, col_code, res_code, cand, cand_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic sample, scan_end, none, single, last, accept;
  // closure counts saturate at 2, which is all that distinguishes SINGLE from MULTI
  always_comb begin
    closed = ~row_in;
    col_n = (closed == 4'd0) ? 2'd0 : ((closed & (closed - 4'd1)) == 4'd0) ? 2'd1 : 2'd2;
    row_idx = closed[0] ? 2'd0 : closed[1] ? 2'd1 : closed[2] ? 2'd2 : 2'd3;
    col_code = KEY_MAP[{row_idx, col, 2'b00} +: 4];
    tot_n = (acc_n[1] | col_n[1] | (acc_n[0] & col_n[0])) ? 2'd2 : (acc_n | col_n);
    res_code = (acc_n == 2'd0) ? col_code : acc_code;
    sample = div_cnt == DW'(SCAN_DIV - 1);
    scan_end = sample && col == 2'd3;
    none = tot_n == 2'd0;
    single = tot_n == 2'd1;
    cnt_inc = cnt + CW'(1);
    last = cnt_inc == CW'(DEBOUNCE_SCANS);
    accept = scan_end && state == DEBOUNCE && single && res_code == cand && last;
  end
  // debounce FSM, advanced only when a full scan result is available
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cand_n = cand;
    if (scan_end)
      case (state)
        IDLE: if (single) begin state_n = DEBOUNCE; cand_n = res_code; cnt_n = CW'(1); end
        DEBOUNCE:
          if (single && res_code == cand) begin
            state_n = last ? HELD : DEBOUNCE;
            cnt_n = last ? '0 : cnt_inc;
          end else begin
            state_n = IDLE;
            cnt_n = '0;
          end
        HELD: if (none) begin state_n = RELEASE; cnt_n = CW'(1); end
        default:
          if (!none) begin
            state_n = HELD;
            cnt_n = '0;
          end else begin
            state_n = last ? IDLE : RELEASE;
            cnt_n = last ? '0 : cnt_inc;
          end
      endcase
  end
  // column scanning, scan accumulation, FSM state and output buffer
  always_ff @(posedge clk)
    if (rst) begin
      div_cnt <= '0;
      col <= 2'd0;
      acc_n <= 2'd0;
      acc_code <= 4'd0;
      state <= IDLE;
      cnt <= '0;
      cand <= 4'd0;
      key_code <= 5'd0;
      key_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      div_cnt <= sample ? '0 : div_cnt + DW'(1);
      if (sample) begin
        col <= col + 2'd1;
        acc_n <= scan_end ? 2'd0 : tot_n;
        acc_code <= res_code;
      end
      state <= state_n;
      cnt <= cnt_n;
      cand <= cand_n;
      overflow <= accept && key_valid && !key_ready;
      if (accept && (!key_valid || key_ready)) begin
        key_code <= {1'b0, cand};
        key_valid <= 1'b1;
      end else if (key_valid && key_ready)
        key_valid <= 1'b0;
    end
  assign col_out = ~(4'b0001 << col);
  assign key_held = state[1];
endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: keypad emulation with a scan-level reference model and a transfer scoreboard
module tb_keypad_encoder;
  localparam int SD = 4, DS = 3, SCAN = 4 * SD;
  logic clk = 0, rst = 1, key_ready = 1;
  logic [3:0] row_in, col_out;
  logic [4:0] key_code;
  logic key_valid, key_held, overflow;
  keypad_encoder #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out), .key_code(key_code),
    .key_valid(key_valid), .key_ready(key_ready), .key_held(key_held), .overflow(overflow)
  );
  always #5 clk = ~clk;
  int keymap[16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  logic [15:0] keys = 16'd0;
  int ready_mode = 0;
  int checks = 0, errors = 0;
  int pos = 0, run = 0, cand = 0, m_code = 0;
  bit m_valid = 0, m_down = 0, m_ovf = 0, started = 0;
  int q[$];
  // physical keypad: a closed key pulls its row low while its column is driven
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (col_out[c] == 1'b0 && keys[r*4+c]) row_in[r] = 1'b0;
  end
  function automatic int scan_result(logic [15:0] m);
    int n, k;
    n = 0;
    k = 0;
    for (int i = 0; i < 16; i++) if (m[i]) begin n++; k = keymap[i]; end
    return n == 0 ? -1 : n > 1 ? -2 : k;
  endfunction
  // key accepted after DS identical single-key scans; release needs DS empty scans
  function automatic bit scan_model(int r);
    bit acc;
    acc = 0;
    if (!m_down) begin
      if (run > 0) run = (r == cand) ? run + 1 : 0;
      else if (r >= 0) begin cand = r; run = 1; end
      if (run == DS) begin acc = 1; m_down = 1; run = 0; end
    end else begin
      run = (r == -1) ? run + 1 : 0;
      if (run == DS) begin m_down = 0; run = 0; end
    end
    return acc;
  endfunction
  task automatic step();
    bit rdy, acc;
    @(posedge clk);
    rdy = key_ready;
    if (rst) begin
      pos = 0; run = 0; cand = 0; m_code = 0;
      m_valid = 0; m_down = 0; m_ovf = 0;
      q.delete();
    end else begin
      acc = (pos == SCAN - 1) ? scan_model(scan_result(keys)) : 1'b0;
      pos = (pos + 1) % SCAN;
      m_ovf = 0;
      if (acc && (!m_valid || rdy)) begin
        m_valid = 1; m_code = cand; q.push_back(cand);
      end else if (acc) m_ovf = 1;
      else if (m_valid && rdy) m_valid = 0;
    end
    #1;
    key_ready = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
  endtask
  task automatic run_cycles(logic [15:0] m, int n);
    keys = m;
    repeat (n) step();
  endtask
  task automatic run_scan(logic [15:0] m, int n);
    run_cycles(m, n * SCAN);
  endtask
  task automatic set_ready(int mode);
    ready_mode = mode;
    key_ready = mode != 1;
  endtask
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: per-cycle output checks and scoreboard pop on every transfer
  always @(negedge clk)
    if (started) begin
      chk("col_out", col_out, 15 ^ (1 << (pos / SD)));
      chk("key_valid", key_valid, m_valid);
      chk("key_code", key_code, m_code);
      chk("key_held", key_held, m_down);
      chk("overflow", overflow, m_ovf);
      if (key_valid && key_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL xfer_unexpected actual=%0d required=none", key_code);
        end else chk("xfer_code", key_code, q.pop_front());
      end
    end
  initial begin
    int sel;
    logic [15:0] m;
    rst = 1;
    step();
    started = 1;
    step();
    rst = 0;
    run_scan(16'h0020, 5);
    run_scan(16'h0000, 4);
    repeat (3) begin run_scan(16'h4000, 1); run_scan(16'h0000, 1); end
    run_scan(16'h0000, 2);
    run_scan(16'h0401, 10);
    run_scan(16'h0001, 4);
    run_scan(16'h0000, 4);
    set_ready(1);
    run_scan(16'h0100, 4);
    run_scan(16'h0000, 4);
    run_scan(16'h0008, 4);
    run_scan(16'h0000, 4);
    set_ready(0);
    run_scan(16'h0000, 1);
    run_scan(16'h2000, 4);
    run_scan(16'h0000, 2);
    run_scan(16'h2000, 4);
    run_scan(16'h0000, 3);
    run_scan(16'h2000, 4);
    run_scan(16'h0000, 4);
    run_cycles(16'h8000, SCAN + 5);
    rst = 1;
    step();
    rst = 0;
    run_scan(16'h8000, 5);
    run_scan(16'h0000, 4);
    set_ready(2);
    repeat (60) begin
      sel = $urandom_range(0, 9);
      m = 16'd0;
      if (sel >= 3) m[$urandom_range(0, 15)] = 1'b1;
      if (sel >= 8) m[$urandom_range(0, 15)] = 1'b1;
      run_scan(m, $urandom_range(1, 5));
    end
    set_ready(0);
    run_scan(16'h0000, 4);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
